// File: rtl/io_arbiter_pkg.sv
// Shared types and default sizes for the J1 I/O bus arbiter and its helpers.
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_RD   = 2'd1,
    CMD_WR   = 2'd2
  } cmd_t;

  localparam int DEF_N           = 2;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_WAIT_STATES = 0;
  localparam int CNT_W           = 4;

  // Write wins when a master raises both command bits.
  function automatic cmd_t decode_cmd(input logic wr, input logic rd);
    cmd_t cmd;
    if (wr) begin
      cmd = CMD_WR;
    end else if (rd) begin
      cmd = CMD_RD;
    end else begin
      cmd = CMD_NONE;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/io_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping modulo N.
module rr_picker
  import io_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [PTR_W-1:0] winner_o
);

  logic [PTR_W-1:0] idx_s;

  // Scan from the farthest offset down so the closest requester is kept last.
  always_comb begin
    idx_s    = {PTR_W{1'b0}};
    winner_o = {PTR_W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      idx_s    = PTR_W'((int'(ptr_i) + k) % N);
      winner_o = req_i[idx_s] ? idx_s : winner_o;
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/io_arbiter.sv
// Round-robin arbiter sharing the J1 I/O slave bus between N masters; one
// registered access per grant with a programmable strobe length.
module io_arbiter
  import io_arb_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N-1:0]        m_req,
  input  logic [N-1:0]        m_wr,
  input  logic [N-1:0]        m_rd,
  input  logic [N*ADDR_W-1:0] m_addr,
  input  logic [N*DATA_W-1:0] m_wdata,
  output logic [N-1:0]        m_ack,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                io_rd,
  output logic                io_wr,
  output logic [ADDR_W-1:0]   io_addr,
  output logic [DATA_W-1:0]   io_dout,
  input  logic [DATA_W-1:0]   io_din,
  output logic                busy
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ACK_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [N-1:0]        ack_q, ack_d;
  logic                io_rd_q, io_rd_d;
  logic                io_wr_q, io_wr_d;

  logic                pick_valid_s;
  logic [PTR_W-1:0]    pick_idx_s;
  int                  pick_sel_s;

  rr_picker #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .req_i    (m_req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid_s),
    .winner_o (pick_idx_s)
  );

  assign pick_sel_s = int'(pick_idx_s);

  // Next-state and registered-output logic of the grant/access/ack sequence.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = {N{1'b0}};
    io_rd_d = 1'b0;
    io_wr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d = ACCESS;
          win_d   = pick_idx_s;
          addr_d  = m_addr[pick_sel_s*ADDR_W +: ADDR_W];
          wdata_d = m_wdata[pick_sel_s*DATA_W +: DATA_W];
          cmd_d   = decode_cmd(m_wr[pick_idx_s], m_rd[pick_idx_s]);
          cnt_d   = CNT_W'(WAIT_STATES);
          io_wr_d = (cmd_d == CMD_WR);
          io_rd_d = (cmd_d == CMD_RD);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Last strobe cycle: sample the OR'ed slave data and raise the ack.
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = DONE;
          ack_d   = ACK_ONE << win_q;
          if (cmd_q == CMD_RD) begin
            rdata_d = io_din;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          io_rd_d = (cmd_q == CMD_RD);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (win_q == PTR_W'(N - 1)) begin
          ptr_d = {PTR_W{1'b0}};
        end else begin
          ptr_d = win_q + PTR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q   <= CMD_NONE;
      ptr_q   <= {PTR_W{1'b0}};
      win_q   <= {PTR_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      rdata_q <= {DATA_W{1'b0}};
      ack_q   <= {N{1'b0}};
      io_rd_q <= 1'b0;
      io_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      io_rd_q <= io_rd_d;
      io_wr_q <= io_wr_d;
    end
  end

  assign m_ack   = ack_q;
  assign m_rdata = rdata_q;
  assign io_rd   = io_rd_q;
  assign io_wr   = io_wr_q;
  assign io_addr = addr_q;
  assign io_dout = wdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: directed scenarios followed by random
// requests, checked cycle by cycle against a transaction-level model.
module tb_io_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int WS = 3;
  localparam logic [AW-1:0] LEDG = 16'h0040;
  localparam logic [AW-1:0] SW   = 16'h0060;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    m_req, m_wr, m_rd;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N-1:0]    m_ack;
  logic [DW-1:0]   m_rdata;
  logic            io_rd, io_wr;
  logic [AW-1:0]   io_addr;
  logic [DW-1:0]   io_dout, io_din;
  logic            busy;

  int tests = 0;
  int fails = 0;
  int ptr_m = 0;
  int last_win = -1;
  logic [DW-1:0] rdata_m = 16'h0000;

  io_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m_req   (m_req),
    .m_wr    (m_wr),
    .m_rd    (m_rd),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_din  (io_din),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One grant from the current IDLE cycle through the following IDLE cycle.
  task automatic run_txn(input bit keep, input bit withdraw);
    int w;
    int cmd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = pick(m_req, ptr_m);
    if (w < 0) begin
      tick();
      chk("idle_busy", busy, 64'd0);
      chk("idle_noack", m_ack, 64'd0);
      return;
    end
    a   = m_addr[w*AW +: AW];
    d   = m_wdata[w*DW +: DW];
    cmd = m_wr[w] ? 2 : (m_rd[w] ? 1 : 0);
    for (int c = 1; c <= WS + 1; c++) begin
      tick();
      chk("acc_wr", io_wr, (cmd == 2 && c == 1) ? 64'd1 : 64'd0);
      chk("acc_rd", io_rd, (cmd == 1) ? 64'd1 : 64'd0);
      chk("acc_addr", io_addr, a);
      chk("acc_dout", io_dout, d);
      chk("acc_ack", m_ack, 64'd0);
      chk("acc_busy", busy, 64'd1);
      if (withdraw && c == 1) m_req[w] = 1'b0;
    end
    if (cmd == 1) rdata_m = io_din;
    tick();
    chk("done_ack", m_ack, 64'd1 << w);
    chk("done_wr", io_wr, 64'd0);
    chk("done_rd", io_rd, 64'd0);
    chk("done_rdata", m_rdata, rdata_m);
    chk("done_busy", busy, 64'd1);
    ptr_m    = (w + 1) % N;
    last_win = w;
    if (!keep) m_req[w] = 1'b0;
    tick();
    chk("post_ack", m_ack, 64'd0);
    chk("post_busy", busy, 64'd0);
    chk("post_rdata", m_rdata, rdata_m);
  endtask

  initial begin
    reset_n = 1'b0;
    m_req = '0; m_wr = '0; m_rd = '0; m_addr = '0; m_wdata = '0; io_din = '0;
    #3;
    chk("rst_rd", io_rd, 64'd0);
    chk("rst_wr", io_wr, 64'd0);
    chk("rst_addr", io_addr, 64'd0);
    chk("rst_dout", io_dout, 64'd0);
    chk("rst_ack", m_ack, 64'd0);
    chk("rst_rdata", m_rdata, 64'd0);
    chk("rst_busy", busy, 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single write by master 0.
    m_addr[0 +: AW] = LEDG; m_wdata[0 +: DW] = 16'h00A5;
    m_wr = 2'b01; m_rd = 2'b00; m_req = 2'b01;
    run_txn(1'b0, 1'b0);
    chk("wr_winner", last_win, 64'd0);

    // Single read by master 1 with slave data 0x02F0.
    m_addr[AW +: AW] = SW; io_din = 16'h02F0;
    m_wr = 2'b00; m_rd = 2'b10; m_req = 2'b10;
    run_txn(1'b0, 1'b0);
    chk("rd_value", m_rdata, 64'h02F0);

    // Continuous contention alternates grants starting from master 0.
    m_wr = 2'b11; m_rd = 2'b00; m_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b0);
      chk("rr_order", last_win, i % 2);
    end
    m_req = 2'b00;

    // Both command bits: write only.
    m_wr = 2'b01; m_rd = 2'b01; m_req = 2'b01;
    run_txn(1'b0, 1'b0);

    // Null access: ack without strobes, read data untouched.
    io_din = 16'hFFFF;
    m_wr = 2'b00; m_rd = 2'b00; m_req = 2'b10;
    run_txn(1'b0, 1'b0);
    chk("null_rdata", m_rdata, 64'h02F0);

    // Request withdrawn during ACCESS still completes.
    io_din = 16'h1234;
    m_rd = 2'b01; m_req = 2'b01;
    run_txn(1'b0, 1'b1);
    chk("wd_winner", last_win, 64'd0);

    // Reset in the third ACCESS cycle of a read by master 1.
    m_rd = 2'b11; m_wr = 2'b00; m_req = 2'b11;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk("pre_rst_rd", io_rd, 64'd1);
    end
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rd", io_rd, 64'd0);
    chk("mid_rst_busy", busy, 64'd0);
    chk("mid_rst_ack", m_ack, 64'd0);
    tick();
    chk("mid_rst_ack2", m_ack, 64'd0);
    tick();
    reset_n = 1'b1;
    ptr_m = 0; rdata_m = 16'h0000;
    run_txn(1'b0, 1'b0);
    chk("post_rst_win", last_win, 64'd0);

    // Random traffic with persistent requests.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_req[i] && $urandom_range(0, 1) == 1) begin
          m_wr[i] = 1'($urandom_range(0, 1));
          m_rd[i] = 1'($urandom_range(0, 1));
          m_addr[i*AW +: AW]  = AW'($urandom);
          m_wdata[i*DW +: DW] = DW'($urandom);
          m_req[i] = 1'b1;
        end
      end
      io_din = DW'($urandom);
      run_txn(1'b0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
